// File: rtl/spi_slave_ram_if.sv
// ---------------------------------------------------------------------------
// spi_slave_ram_if
//   SPI slave bridging an external master to the single-port RAM wrapper.
//   A frame is a command-MSB bit followed by DATA_W+2 payload bits
//   ({cmd[1:0], word}). The payload is presented to the RAM on rx_data with a
//   one-cycle rx_valid. Read-data frames then wait for tx_valid and shift the
//   RAM word back out on MISO. clk is the SPI bit clock; MOSI/SS_n are
//   synchronous to it.
//
// Parameters
//   DATA_W     RAM address/data width
//   MSB_FIRST  word bit order on MOSI/MISO (cmd bits are always sent first)
//   RD_TMO     cycles to wait for tx_valid before flagging frame_err
//
// Ports
//   clk        bit clock, all logic on posedge
//   rst        asynchronous active-high reset
//   SS_n       slave select, active low; high ends or aborts the frame
//   MOSI       serial data from master
//   tx_valid   RAM read data valid (only looked at while awaiting read data)
//   tx_data    RAM read data
//   MISO       registered serial data to master
//   rx_valid   one-cycle pulse, rx_data holds a complete frame
//   rx_data    {cmd[1:0], word} to RAM, held between frames
//   frame_err  one-cycle pulse on aborted frame or read timeout
//   busy       high whenever the FSM is not idle
//
// state     | meaning
// ----------+------------------------------------------------------------
// IDLE      | waiting for SS_n low
// CHK_CMD   | sample command MSB, pick WRITE / READ_ADD / READ_DATA
// WRITE     | shift in payload, deliver it, then ignore MOSI until SS_n high
// READ_ADD  | shift in payload, deliver it, mark read address pending
// READ_DATA | shift in payload, deliver it, then wait (bounded) for tx_valid
// TX        | shift the latched RAM word out on MISO
// ---------------------------------------------------------------------------
module spi_slave_ram_if #(
    parameter int DATA_W    = 8,
    parameter bit MSB_FIRST = 1'b1,
    parameter int RD_TMO    = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              SS_n,
    input  logic              MOSI,
    input  logic              tx_valid,
    input  logic [DATA_W-1:0] tx_data,
    output logic              MISO,
    output logic              rx_valid,
    output logic [DATA_W+1:0] rx_data,
    output logic              frame_err,
    output logic              busy
);

    localparam int CNT_W = $clog2(DATA_W + 3);
    localparam int TMO_W = $clog2(RD_TMO + 1);

    localparam logic [CNT_W-1:0] FRAME_CNT = CNT_W'(DATA_W + 2);
    localparam logic [CNT_W-1:0] WORD_CNT  = CNT_W'(DATA_W);
    localparam logic [CNT_W-1:0] CMD_CNT   = CNT_W'(2);
    localparam logic [TMO_W-1:0] TMO_LOAD  = TMO_W'(RD_TMO);

    typedef enum logic [2:0] {
        IDLE,
        CHK_CMD,
        WRITE,
        READ_ADD,
        READ_DATA,
        TX
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [TMO_W-1:0]    tmo_q, tmo_d;
    logic                done_q, done_d;
    logic [1:0]          cmd_q, cmd_d;
    logic [DATA_W-1:0]   sreg_q, sreg_d;
    logic                miso_q, miso_d;
    logic                rx_valid_q, rx_valid_d;
    logic [DATA_W+1:0]   rx_data_q, rx_data_d;
    logic                frame_err_q, frame_err_d;
    logic                rd_addr_pend_q, rd_addr_pend_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            tmo_q          <= '0;
            done_q         <= 1'b0;
            cmd_q          <= '0;
            sreg_q         <= '0;
            miso_q         <= 1'b0;
            rx_valid_q     <= 1'b0;
            rx_data_q      <= '0;
            frame_err_q    <= 1'b0;
            rd_addr_pend_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            tmo_q          <= tmo_d;
            done_q         <= done_d;
            cmd_q          <= cmd_d;
            sreg_q         <= sreg_d;
            miso_q         <= miso_d;
            rx_valid_q     <= rx_valid_d;
            rx_data_q      <= rx_data_d;
            frame_err_q    <= frame_err_d;
            rd_addr_pend_q <= rd_addr_pend_d;
        end
    end

    // done_q marks that the current phase has finished (payload delivered,
    // or TX word fully shifted out). An SS_n exit before that is an abort.
    // In READ_DATA after delivery, tmo_q counts down the remaining wait;
    // reaching zero without tx_valid means the timeout already fired.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        tmo_d          = tmo_q;
        done_d         = done_q;
        cmd_d          = cmd_q;
        sreg_d         = sreg_q;
        miso_d         = miso_q;
        rx_valid_d     = 1'b0;
        rx_data_d      = rx_data_q;
        frame_err_d    = 1'b0;
        rd_addr_pend_d = rd_addr_pend_q;

        if (state_q != IDLE && SS_n) begin
            state_d     = IDLE;
            cnt_d       = '0;
            tmo_d       = '0;
            done_d      = 1'b0;
            cmd_d       = '0;
            sreg_d      = '0;
            miso_d      = 1'b0;
            frame_err_d = !done_q;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!SS_n) begin
                        state_d = CHK_CMD;
                    end
                end

                CHK_CMD: begin
                    cnt_d  = '0;
                    done_d = 1'b0;
                    if (!MOSI) begin
                        state_d = WRITE;
                    end else if (rd_addr_pend_q) begin
                        state_d = READ_DATA;
                    end else begin
                        state_d = READ_ADD;
                    end
                end

                WRITE, READ_ADD, READ_DATA: begin
                    if (!done_q) begin
                        if (cnt_q != FRAME_CNT) begin
                            if (cnt_q < CMD_CNT) begin
                                cmd_d = {cmd_q[0], MOSI};
                            end else if (MSB_FIRST) begin
                                sreg_d = {sreg_q[DATA_W-2:0], MOSI};
                            end else begin
                                sreg_d = {MOSI, sreg_q[DATA_W-1:1]};
                            end
                            cnt_d = cnt_q + CNT_W'(1);
                        end else begin
                            rx_data_d  = {cmd_q, sreg_q};
                            rx_valid_d = 1'b1;
                            done_d     = 1'b1;
                            if (state_q == READ_ADD) begin
                                rd_addr_pend_d = 1'b1;
                            end
                            if (state_q == READ_DATA) begin
                                tmo_d = TMO_LOAD;
                            end
                        end
                    end else if (state_q == READ_DATA && tmo_q != '0) begin
                        // tx_valid wins over the timeout on the same edge
                        if (tx_valid) begin
                            sreg_d  = tx_data;
                            state_d = TX;
                            cnt_d   = '0;
                            done_d  = 1'b0;
                            tmo_d   = '0;
                        end else begin
                            tmo_d = tmo_q - TMO_W'(1);
                            if (tmo_q == TMO_W'(1)) begin
                                frame_err_d = 1'b1;
                            end
                        end
                    end
                end

                TX: begin
                    if (!done_q) begin
                        if (cnt_q != WORD_CNT) begin
                            if (MSB_FIRST) begin
                                miso_d = sreg_q[DATA_W-1];
                                sreg_d = {sreg_q[DATA_W-2:0], 1'b0};
                            end else begin
                                miso_d = sreg_q[0];
                                sreg_d = {1'b0, sreg_q[DATA_W-1:1]};
                            end
                            cnt_d = cnt_q + CNT_W'(1);
                        end else begin
                            miso_d         = 1'b0;
                            rd_addr_pend_d = 1'b0;
                            done_d         = 1'b1;
                        end
                    end
                end

                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    assign MISO      = miso_q;
    assign rx_valid  = rx_valid_q;
    assign rx_data   = rx_data_q;
    assign frame_err = frame_err_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_spi_slave_ram_if.sv
// Directed bench for spi_slave_ram_if: an 8-bit MSB-first instance (a) and a
// 16-bit LSB-first instance (b) share clk, rst, SS_n, MOSI and tx_valid.
module tb_spi_slave_ram_if;

    localparam int RD_TMO = 15;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ss_n = 1'b1;
    logic        mosi = 1'b0;
    logic        tx_valid = 1'b0;
    logic [7:0]  tx_data_a = '0;
    logic [15:0] tx_data_b = '0;

    logic        miso_a, rx_valid_a, frame_err_a, busy_a;
    logic [9:0]  rx_data_a;
    logic        miso_b, rx_valid_b, frame_err_b, busy_b;
    logic [17:0] rx_data_b;

    int checks = 0;
    int failures = 0;
    int rxv_cnt = 0;
    int err_cnt = 0;
    int n_rx, n_err, first, miso_seen;
    logic [15:0] rev;
    logic [15:0] word;

    spi_slave_ram_if #(.DATA_W(8), .MSB_FIRST(1'b1), .RD_TMO(RD_TMO)) u_dut_a (
        .clk(clk), .rst(rst), .SS_n(ss_n), .MOSI(mosi),
        .tx_valid(tx_valid), .tx_data(tx_data_a),
        .MISO(miso_a), .rx_valid(rx_valid_a), .rx_data(rx_data_a),
        .frame_err(frame_err_a), .busy(busy_a)
    );

    spi_slave_ram_if #(.DATA_W(16), .MSB_FIRST(1'b0), .RD_TMO(RD_TMO)) u_dut_b (
        .clk(clk), .rst(rst), .SS_n(ss_n), .MOSI(mosi),
        .tx_valid(tx_valid), .tx_data(tx_data_b),
        .MISO(miso_b), .rx_valid(rx_valid_b), .rx_data(rx_data_b),
        .frame_err(frame_err_b), .busy(busy_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rx_valid_a)  rxv_cnt <= rxv_cnt + 1;
        if (frame_err_a) err_cnt <= err_cnt + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic frame_start();
        ss_n = 1'b0;
        mosi = 1'b0;
        @(negedge clk);
    endtask

    task automatic send_bits(input logic [31:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            mosi = bits[i];
            @(negedge clk);
        end
    endtask

    task automatic frame_end();
        ss_n = 1'b1;
        mosi = 1'b0;
        @(negedge clk);
    endtask

    // CHK bit + 10 payload bits, then the delivery cycle
    task automatic rx_frame_a(input logic [10:0] bits, input logic [9:0] exp, input string tag);
        frame_start();
        send_bits({21'b0, bits}, 11);
        check_eq({tag, "_early"}, rx_valid_a, 1'b0);
        @(negedge clk);
        check_eq({tag, "_rxv"}, rx_valid_a, 1'b1);
        check_eq({tag, "_data"}, rx_data_a, exp);
    endtask

    task automatic expect_tx_a(input logic [7:0] d, input string tag);
        for (int i = 7; i >= 0; i--) begin
            @(negedge clk);
            check_eq({tag, "_bit"}, miso_a, d[i]);
        end
        @(negedge clk);
        check_eq({tag, "_after"}, miso_a, 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        @(negedge clk);
        check_eq("rst_miso", miso_a, 1'b0);
        check_eq("rst_rx_valid", rx_valid_a, 1'b0);
        check_eq("rst_rx_data", rx_data_a, 10'h000);
        check_eq("rst_frame_err", frame_err_a, 1'b0);
        check_eq("rst_busy", busy_a, 1'b0);
        rst = 1'b0;
        @(negedge clk);

        // write frame
        n_rx = rxv_cnt; n_err = err_cnt;
        rx_frame_a(11'b0_00_10100101, 10'h0A5, "wr");
        check_eq("wr_busy", busy_a, 1'b1);
        @(negedge clk);
        check_eq("wr_pulse_end", rx_valid_a, 1'b0);
        cyc(3);
        frame_end();
        check_eq("wr_busy_end", busy_a, 1'b0);
        check_eq("wr_rx_count", rxv_cnt - n_rx, 1);
        check_eq("wr_err_count", err_cnt - n_err, 0);

        // read pair
        rx_frame_a(11'b1_10_11000011, 10'h2C3, "rd_add");
        cyc(RD_TMO + 3);
        frame_end();
        n_err = err_cnt;
        rx_frame_a(11'b1_11_00000000, 10'h300, "rd_data");
        tx_valid = 1'b1; tx_data_a = 8'h5A;
        @(negedge clk);
        tx_valid = 1'b0;
        check_eq("tx_pre_miso", miso_a, 1'b0);
        expect_tx_a(8'h5A, "tx5a");
        cyc(2);
        frame_end();
        check_eq("tx5a_err_count", err_cnt - n_err, 0);

        // pending address cleared: next read is READ_ADD, no timeout
        n_err = err_cnt;
        rx_frame_a(11'b1_10_00010010, 10'h212, "rd_add2");
        cyc(RD_TMO + 5);
        frame_end();
        check_eq("pend_cleared", err_cnt - n_err, 0);

        // read-data timeout
        n_err = err_cnt;
        rx_frame_a(11'b1_11_11111111, 10'h3FF, "tmo");
        first = 0; miso_seen = 0;
        for (int k = 1; k <= RD_TMO + 4; k++) begin
            @(negedge clk);
            if (frame_err_a && first == 0) first = k;
            if (miso_a) miso_seen = 1;
        end
        check_eq("tmo_latency", first, RD_TMO);
        check_eq("tmo_miso", miso_seen, 0);
        frame_end();
        check_eq("tmo_single", err_cnt - n_err, 1);

        // tx_valid on the timeout edge is accepted
        n_err = err_cnt;
        rx_frame_a(11'b1_11_00000000, 10'h300, "edge");
        cyc(RD_TMO - 1);
        tx_valid = 1'b1; tx_data_a = 8'hC3;
        @(negedge clk);
        tx_valid = 1'b0;
        check_eq("edge_no_err", frame_err_a, 1'b0);
        expect_tx_a(8'hC3, "txc3");
        frame_end();
        check_eq("edge_err_count", err_cnt - n_err, 0);

        // abort after 5 payload bits
        n_rx = rxv_cnt;
        frame_start();
        send_bits(32'b0_00101, 6);
        ss_n = 1'b1;
        @(negedge clk);
        check_eq("abort_err", frame_err_a, 1'b1);
        check_eq("abort_busy", busy_a, 1'b0);
        check_eq("abort_rxv", rx_valid_a, 1'b0);
        check_eq("abort_hold", rx_data_a, 10'h300);
        @(negedge clk);
        check_eq("abort_pulse", frame_err_a, 1'b0);

        // SS_n high on the same edge as the last payload bit
        frame_start();
        send_bits(32'b0_00_1010010, 10);
        mosi = 1'b1; ss_n = 1'b1;
        @(negedge clk);
        check_eq("lastbit_err", frame_err_a, 1'b1);
        check_eq("lastbit_rxv", rx_valid_a, 1'b0);
        cyc(2);
        check_eq("abort_rx_count", rxv_cnt - n_rx, 0);

        // reset during TX
        rx_frame_a(11'b1_10_00000001, 10'h201, "rst_add");
        frame_end();
        rx_frame_a(11'b1_11_00000000, 10'h300, "rst_data");
        tx_valid = 1'b1; tx_data_a = 8'hFF;
        @(negedge clk);
        tx_valid = 1'b0;
        cyc(3);
        check_eq("pre_rst_miso", miso_a, 1'b1);
        rst = 1'b1; ss_n = 1'b1;
        #1;
        check_eq("rst_tx_miso", miso_a, 1'b0);
        check_eq("rst_tx_busy", busy_a, 1'b0);
        check_eq("rst_tx_rx_data", rx_data_a, 10'h000);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_err = err_cnt;
        rx_frame_a(11'b1_10_00000011, 10'h203, "post_rst");
        cyc(RD_TMO + 5);
        frame_end();
        check_eq("post_rst_read_add", err_cnt - n_err, 0);

        // 16-bit LSB-first instance
        word = 16'h1234;
        for (int i = 0; i < 16; i++) rev[i] = word[15 - i];
        frame_start();
        send_bits({13'b0, 3'b000, rev}, 19);
        @(negedge clk);
        check_eq("b_rxv", rx_valid_b, 1'b1);
        check_eq("b_data_1234", rx_data_b, 18'h01234);
        frame_end();
        word = 16'h8001;
        for (int i = 0; i < 16; i++) rev[i] = word[15 - i];
        frame_start();
        send_bits({13'b0, 3'b001, rev}, 19);
        @(negedge clk);
        check_eq("b_data_8001", rx_data_b, 18'h18001);
        frame_end();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
